// File: rtl/tetrimino_spawner_if.sv
// Handshake and bitmap bundle between the game controller and tetrimino_spawner.
// master = controller side, slave = spawner side.
interface tetrimino_spawner_if #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
);
    logic                         spawnReq;
    logic [2:0]                   spawnType;
    logic                         rotReq;
    logic [HEIGHT-1:0][WIDTH-1:0] matrixOut;
    logic [2:0]                   typeOut;
    logic [1:0]                   rotOut;
    logic                         valid;
    logic                         spawnAck;

    modport master (
        output spawnReq, spawnType, rotReq,
        input  matrixOut, typeOut, rotOut, valid, spawnAck
    );

    modport slave (
        input  spawnReq, spawnType, rotReq,
        output matrixOut, typeOut, rotOut, valid, spawnAck
    );
endinterface

// File: rtl/tetrimino_spawner.sv
// Registered tetromino source: LFSR draw (7-bag when TETRIMINO_BAG_EN is defined),
// clockwise rotation and request/acknowledge handshake into a HEIGHT x WIDTH bitmap.
module tetrimino_spawner #(
    parameter int          WIDTH     = 8,
    parameter int          HEIGHT    = 8,
    parameter int          SPAWN_MSB = 5,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input logic                clk,
    input logic                rst,
    tetrimino_spawner_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StDraw, StRender, StHold} state_e;

    state_e                       state_q, state_d;
    logic [15:0]                  lfsr_q;
    logic [2:0]                   type_q, type_d;
    logic [1:0]                   rot_q, rot_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [HEIGHT-1:0][WIDTH-1:0] matrix_q, matrix_d;
    logic [2:0]                   type_out_q, type_out_d;
    logic [1:0]                   rot_out_q, rot_out_d;
    logic                         valid_q, valid_d;
    logic                         ack_q, ack_d;
    logic [2:0]                   cand;
    logic                         accept;
    logic [2:0]                   fallback;
    logic [1:0]                   rot_next;
`ifdef TETRIMINO_BAG_EN
    logic [6:0]                   bag_q, bag_d;
    logic [7:0]                   bag_ext, bag_ext_n;
`endif

    // Box cell b[r][c] in a 4x4 box, rotated clockwise rot times.
    function automatic logic [3:0][3:0] shape(input logic [2:0] t, input logic [1:0] rot);
        logic [3:0][3:0] b;
        logic [3:0][3:0] n;
        b = '0;
        case (t)
            3'd1: begin b[0][1] = 1'b1; b[1][1] = 1'b1; b[2][1] = 1'b1; b[2][2] = 1'b1; end
            3'd2: begin b[0][1] = 1'b1; b[0][2] = 1'b1; b[1][1] = 1'b1; b[1][2] = 1'b1; end
            3'd3: begin b[0][1] = 1'b1; b[0][2] = 1'b1; b[1][0] = 1'b1; b[1][1] = 1'b1; end
            3'd4: begin b[0][0] = 1'b1; b[0][1] = 1'b1; b[0][2] = 1'b1; b[1][1] = 1'b1; end
            3'd5: begin b[0][0] = 1'b1; b[0][1] = 1'b1; b[1][1] = 1'b1; b[1][2] = 1'b1; end
            3'd6: begin b[0][2] = 1'b1; b[1][2] = 1'b1; b[2][2] = 1'b1; b[3][2] = 1'b1; end
            3'd7: begin b[0][2] = 1'b1; b[1][2] = 1'b1; b[2][1] = 1'b1; b[2][2] = 1'b1; end
            default: ;
        endcase
        for (int s = 0; s < 3; s++) begin
            if (s < int'(rot) && t != 3'd2) begin
                n = '0;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        if (b[r][c]) begin
                            if (t == 3'd6)  n[c][3-r] = 1'b1;
                            else if (r < 3) n[c][2-r] = 1'b1;
                        end
                    end
                end
                b = n;
            end
        end
        return b;
    endfunction

    // Box column 0 lands on SPAWN_MSB, later columns move toward bit 0.
    function automatic logic [HEIGHT-1:0][WIDTH-1:0] place(input logic [3:0][3:0] b);
        logic [HEIGHT-1:0][WIDTH-1:0] m;
        m = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                m[r][SPAWN_MSB-k] = b[r][k];
            end
        end
        return m;
    endfunction

    assign cand     = lfsr_q[2:0];
    assign rot_next = rot_q + 2'd1;

`ifdef TETRIMINO_BAG_EN
    // Bit 0 stands in for the zero candidate so it is always rejected.
    assign bag_ext = {bag_q, 1'b1};
    assign accept  = !bag_ext[cand];
    always_comb begin
        fallback = 3'd1;
        for (int i = 7; i >= 1; i--) begin
            if (!bag_ext[i]) fallback = 3'(i);
        end
    end
    always_comb begin
        bag_ext_n = bag_ext | (8'd1 << type_q);
        bag_d     = bag_q;
        if (state_q == StRender) bag_d = (&bag_ext_n) ? 7'd0 : bag_ext_n[7:1];
    end
`else
    assign accept   = (cand != 3'd0);
    assign fallback = 3'd1;
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        rot_d      = rot_q;
        cnt_d      = cnt_q;
        matrix_d   = matrix_q;
        type_out_d = type_out_q;
        rot_out_d  = rot_out_q;
        valid_d    = valid_q;
        ack_d      = 1'b0;
        case (state_q)
            StIdle, StHold: begin
                if (bus.spawnReq) begin
                    valid_d = 1'b0;
                    rot_d   = 2'd0;
                    if (bus.spawnType != 3'd0) begin
                        type_d  = bus.spawnType;
                        state_d = StRender;
                    end else begin
                        cnt_d   = 3'd0;
                        state_d = StDraw;
                    end
                end else if (state_q == StHold && bus.rotReq) begin
                    rot_d     = rot_next;
                    rot_out_d = rot_next;
                    matrix_d  = place(shape(type_q, rot_next));
                end
            end
            StDraw: begin
                if (accept) begin
                    type_d  = cand;
                    state_d = StRender;
                end else if (cnt_q == 3'd7) begin
                    type_d  = fallback;
                    state_d = StRender;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StRender: begin
                matrix_d   = place(shape(type_q, rot_q));
                type_out_d = type_q;
                rot_out_d  = rot_q;
                valid_d    = 1'b1;
                ack_d      = 1'b1;
                state_d    = StHold;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= SEED;
            type_q     <= 3'd0;
            rot_q      <= 2'd0;
            cnt_q      <= 3'd0;
            matrix_q   <= '0;
            type_out_q <= 3'd0;
            rot_out_q  <= 2'd0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
`ifdef TETRIMINO_BAG_EN
            bag_q      <= 7'd0;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            type_q     <= type_d;
            rot_q      <= rot_d;
            cnt_q      <= cnt_d;
            matrix_q   <= matrix_d;
            type_out_q <= type_out_d;
            rot_out_q  <= rot_out_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
`ifdef TETRIMINO_BAG_EN
            bag_q      <= bag_d;
`endif
        end
    end

    assign bus.matrixOut = matrix_q;
    assign bus.typeOut   = type_out_q;
    assign bus.rotOut    = rot_out_q;
    assign bus.valid     = valid_q;
    assign bus.spawnAck  = ack_q;

endmodule

// File: tb/tb_tetrimino_spawner.sv
// Directed bench for tetrimino_spawner: reset, shapes, rotation, priority, mid-draw reset,
// and random draws (bag permutations when TETRIMINO_BAG_EN is defined).
module tb_tetrimino_spawner;
    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    tetrimino_spawner_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

    tetrimino_spawner #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .SPAWN_MSB(5),
        .SEED     (16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rows(input logic [7:0] r0, r1, r2, r3);
        return {32'h0, r3, r2, r1, r0};
    endfunction

    task automatic spawn_forced(input logic [2:0] t);
        @(negedge clk);
        bus.spawnReq  = 1'b1;
        bus.spawnType = t;
        @(negedge clk);
        bus.spawnReq  = 1'b0;
        bus.spawnType = 3'd0;
        @(negedge clk);
    endtask

    task automatic rotate();
        @(negedge clk);
        bus.rotReq = 1'b1;
        @(negedge clk);
        bus.rotReq = 1'b0;
    endtask

    task automatic spawn_random(output int edges, output logic [2:0] t, output logic ack);
        @(negedge clk);
        bus.spawnReq  = 1'b1;
        bus.spawnType = 3'd0;
        @(negedge clk);
        bus.spawnReq = 1'b0;
        edges = 1;
        while (!bus.valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        t   = bus.typeOut;
        ack = bus.spawnAck;
    endtask

    task automatic test_reset();
        logic [70:0] obs;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {bus.matrixOut, bus.typeOut, bus.rotOut, bus.valid, bus.spawnAck};
            total_cnt++;
            if (obs !== 71'd0) $display("FAIL reset_idle cycle %0d: got %h expected 0", i, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_forced_shapes();
        logic [63:0] exp_tab [8];
        exp_tab[0] = 64'h0;
        exp_tab[1] = rows(8'h10, 8'h10, 8'h18, 8'h00);
        exp_tab[2] = rows(8'h18, 8'h18, 8'h00, 8'h00);
        exp_tab[3] = rows(8'h18, 8'h30, 8'h00, 8'h00);
        exp_tab[4] = rows(8'h38, 8'h10, 8'h00, 8'h00);
        exp_tab[5] = rows(8'h30, 8'h18, 8'h00, 8'h00);
        exp_tab[6] = rows(8'h08, 8'h08, 8'h08, 8'h08);
        exp_tab[7] = rows(8'h08, 8'h08, 8'h18, 8'h00);
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            bus.spawnReq  = 1'b1;
            bus.spawnType = 3'(t);
            @(negedge clk);
            bus.spawnReq  = 1'b0;
            bus.spawnType = 3'd0;
            total_cnt++;
            if (bus.valid !== 1'b0) $display("FAIL valid_clear type %0d: got %b expected 0", t, bus.valid);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (bus.matrixOut !== exp_tab[t])
                $display("FAIL shape type %0d: got %h expected %h", t, bus.matrixOut, exp_tab[t]);
            else pass_cnt++;
            total_cnt++;
            if ({bus.typeOut, bus.rotOut, bus.valid, bus.spawnAck} !== {3'(t), 2'd0, 1'b1, 1'b1})
                $display("FAIL spawn_status type %0d: got %h/%h/%b/%b expected %0d/0/1/1",
                         t, bus.typeOut, bus.rotOut, bus.valid, bus.spawnAck, t);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({bus.valid, bus.spawnAck} !== 2'b10)
                $display("FAIL ack_pulse type %0d: got valid %b ack %b expected 1 0",
                         t, bus.valid, bus.spawnAck);
            else pass_cnt++;
        end
    endtask

    task automatic test_rotation();
        spawn_forced(3'd6);
        rotate();
        total_cnt++;
        if (bus.matrixOut !== rows(8'h00, 8'h00, 8'h3C, 8'h00) || bus.rotOut !== 2'd1 || !bus.valid)
            $display("FAIL rot_I1: got %h rot %0d expected %h rot 1",
                     bus.matrixOut, bus.rotOut, rows(8'h00, 8'h00, 8'h3C, 8'h00));
        else pass_cnt++;
        rotate();
        total_cnt++;
        if (bus.matrixOut !== rows(8'h10, 8'h10, 8'h10, 8'h10) || bus.rotOut !== 2'd2)
            $display("FAIL rot_I2: got %h rot %0d expected %h rot 2",
                     bus.matrixOut, bus.rotOut, rows(8'h10, 8'h10, 8'h10, 8'h10));
        else pass_cnt++;
        rotate();
        total_cnt++;
        if (bus.matrixOut !== rows(8'h00, 8'h3C, 8'h00, 8'h00) || bus.rotOut !== 2'd3)
            $display("FAIL rot_I3: got %h rot %0d expected %h rot 3",
                     bus.matrixOut, bus.rotOut, rows(8'h00, 8'h3C, 8'h00, 8'h00));
        else pass_cnt++;
        rotate();
        total_cnt++;
        if (bus.matrixOut !== rows(8'h08, 8'h08, 8'h08, 8'h08) || bus.rotOut !== 2'd0)
            $display("FAIL rot_I_wrap: got %h rot %0d expected %h rot 0",
                     bus.matrixOut, bus.rotOut, rows(8'h08, 8'h08, 8'h08, 8'h08));
        else pass_cnt++;
        spawn_forced(3'd4);
        rotate();
        total_cnt++;
        if (bus.matrixOut !== rows(8'h08, 8'h18, 8'h08, 8'h00) || bus.rotOut !== 2'd1)
            $display("FAIL rot_T1: got %h rot %0d expected %h rot 1",
                     bus.matrixOut, bus.rotOut, rows(8'h08, 8'h18, 8'h08, 8'h00));
        else pass_cnt++;
        spawn_forced(3'd1);
        rotate();
        rotate();
        total_cnt++;
        if (bus.matrixOut !== rows(8'h30, 8'h10, 8'h10, 8'h00) || bus.rotOut !== 2'd2)
            $display("FAIL rot_L2: got %h rot %0d expected %h rot 2",
                     bus.matrixOut, bus.rotOut, rows(8'h30, 8'h10, 8'h10, 8'h00));
        else pass_cnt++;
        spawn_forced(3'd2);
        rotate();
        total_cnt++;
        if (bus.matrixOut !== rows(8'h18, 8'h18, 8'h00, 8'h00) || bus.rotOut !== 2'd1)
            $display("FAIL rot_O1: got %h rot %0d expected %h rot 1",
                     bus.matrixOut, bus.rotOut, rows(8'h18, 8'h18, 8'h00, 8'h00));
        else pass_cnt++;
    endtask

    task automatic test_priority();
        spawn_forced(3'd1);
        rotate();
        @(negedge clk);
        bus.spawnReq  = 1'b1;
        bus.spawnType = 3'd2;
        bus.rotReq    = 1'b1;
        @(negedge clk);
        bus.spawnReq  = 1'b0;
        bus.spawnType = 3'd0;
        bus.rotReq    = 1'b0;
        total_cnt++;
        if (bus.valid !== 1'b0) $display("FAIL prio_valid_clear: got %b expected 0", bus.valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.typeOut !== 3'd2 || bus.rotOut !== 2'd0
            || bus.matrixOut !== rows(8'h18, 8'h18, 8'h00, 8'h00))
            $display("FAIL prio_spawn: got type %0d rot %0d %h expected type 2 rot 0 %h",
                     bus.typeOut, bus.rotOut, bus.matrixOut, rows(8'h18, 8'h18, 8'h00, 8'h00));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [70:0] obs;
        spawn_forced(3'd4);
        @(negedge clk);
        bus.spawnReq  = 1'b1;
        bus.spawnType = 3'd0;
        @(negedge clk);
        bus.spawnReq = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        obs = {bus.matrixOut, bus.typeOut, bus.rotOut, bus.valid, bus.spawnAck};
        total_cnt++;
        if (obs !== 71'd0) $display("FAIL reset_mid: got %h expected 0", obs);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.valid !== 1'b0 || bus.typeOut !== 3'd0)
            $display("FAIL reset_abandon: got valid %b type %0d expected 0 0", bus.valid, bus.typeOut);
        else pass_cnt++;
    endtask

`ifdef TETRIMINO_BAG_EN
    task automatic test_bag();
        int         edges;
        logic [2:0] t;
        logic       ack;
        logic [7:0] mask;
        for (int round = 0; round < 2; round++) begin
            mask = 8'd0;
            for (int i = 0; i < 7; i++) begin
                spawn_random(edges, t, ack);
                total_cnt++;
                if (edges > 9 || !bus.valid || !ack)
                    $display("FAIL bag_latency round %0d spawn %0d: got %0d edges ack %b expected <=9 ack 1",
                             round, i, edges, ack);
                else pass_cnt++;
                mask = mask | (8'd1 << t);
            end
            total_cnt++;
            if (mask !== 8'hFE) $display("FAIL bag_perm round %0d: got %h expected fe", round, mask);
            else pass_cnt++;
        end
    endtask
`else
    task automatic test_random();
        int         edges;
        logic [2:0] t;
        logic       ack;
        for (int i = 0; i < 100; i++) begin
            spawn_random(edges, t, ack);
            total_cnt++;
            if (edges > 9 || !bus.valid)
                $display("FAIL rand_latency spawn %0d: got %0d edges valid %b expected <=9 valid 1",
                         i, edges, bus.valid);
            else pass_cnt++;
            total_cnt++;
            if (t === 3'd0 || $isunknown(t)) $display("FAIL rand_type spawn %0d: got %0d expected 1..7", i, t);
            else pass_cnt++;
            total_cnt++;
            if (ack !== 1'b1) $display("FAIL rand_ack spawn %0d: got %b expected 1", i, ack);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        bus.spawnReq  = 1'b0;
        bus.spawnType = 3'd0;
        bus.rotReq    = 1'b0;
        test_reset();
        test_forced_shapes();
        test_rotation();
        test_priority();
        test_reset_mid();
`ifdef TETRIMINO_BAG_EN
        test_bag();
`else
        test_random();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tetrimino_spawner.md
# tetrimino_spawner

Registered, parametrised tetromino source for the LED Tetris datapath. On a spawn request it selects a piece type from a 7-bag randomiser (or takes a forced type), then renders that piece in one of four clockwise orientations into a HEIGHT x WIDTH bitmap. The bitmap is held for the game controller to merge into the playfield. It replaces the fixed 8x8 combinational piece lookup and adds rotation, randomised selection and a request/acknowledge handshake.

## Interface
- WIDTH, 8, playfield columns; must be >= 4
- HEIGHT, 8, playfield rows; must be >= 4
- SPAWN_MSB, 5, matrix bit driven by box column 0; must be in [3, WIDTH-1]
- SEED, 16'hACE1, LFSR reset value; must be non-zero
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- spawnReq  in  1  request a new piece
- spawnType  in  3  0 = random draw; 1..7 = forced type
- rotReq  in  1  rotate the current piece 90 degrees clockwise
- matrixOut  out  [HEIGHT-1:0][WIDTH-1:0]  piece bitmap; row 0 is the top row
- typeOut  out  3  current type: 0 none, 1 L, 2 O, 3 S, 4 T, 5 Z, 6 I, 7 J
- rotOut  out  2  current orientation, 0..3
- valid  out  1  high while matrixOut holds a complete piece
- spawnAck  out  1  one-cycle pulse when a new piece first becomes valid

## Operation
- Reset values: all outputs are 0, state is IDLE, bag is empty, LFSR = SEED.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle while not in reset. The draw candidate is lfsr[2:0].
- State machine: IDLE, DRAW, RENDER, HOLD.
  - IDLE/HOLD with spawnReq: clear valid, set rot to 0. If spawnType != 0, latch it and go to RENDER. Otherwise go to DRAW and clear drawCnt.
  - DRAW: accept the candidate if it is non-zero and not marked in the bag. On acceptance, latch the type and go to RENDER.
  - DRAW rejection: increment drawCnt. When drawCnt == 7 and the candidate is also rejected, take the lowest unused type instead. DRAW therefore lasts at most 8 cycles.
  - RENDER: mark the type in the bag. If all 7 types are now marked, clear the bag. Register matrixOut, typeOut and rotOut, set valid, pulse spawnAck, go to HOLD.
  - HOLD with rotReq only: rot <= rot+1 (3 wraps to 0). matrixOut and rotOut update on the same edge; valid stays high.
- Priority: spawnReq beats rotReq in HOLD. rotReq outside HOLD is ignored. spawnReq in DRAW or RENDER is ignored.
- Forced types also mark the bag.
- Shapes are defined in a 4x4 box as (row, col) cells. Box cell (r,k) drives matrixOut[r][SPAWN_MSB-k]. Rows 4..HEIGHT-1 are always 0. Orientation 0:
  - L: (0,1)(1,1)(2,1)(2,2)
  - O: (0,1)(0,2)(1,1)(1,2)
  - S: (0,1)(0,2)(1,0)(1,1)
  - T: (0,0)(0,1)(0,2)(1,1)
  - Z: (0,0)(0,1)(1,1)(1,2)
  - I: (0,2)(1,2)(2,2)(3,2)
  - J: (0,2)(1,2)(2,1)(2,2)
- Clockwise rotation step:
  - I: (r,c) -> (c, 3-r)
  - O: unchanged
  - all others: (r,c) -> (c, 2-r)
- Orientation n applies the step n times.

## Timing
- Forced spawn: spawnReq sampled at edge n -> valid and spawnAck high after edge n+1.
- Random spawn: valid after edge n+1+k, where k = 1..8 DRAW cycles.
- spawnAck is high for exactly one cycle per spawn.
- Rotation: rotReq sampled at edge n -> new bitmap visible after edge n.
- Reset mid-operation: all outputs return to reset values immediately. The interrupted spawn is abandoned.

## Configuration
- TETRIMINO_BAG_EN defined: 7-bag selection as above. Each run of 7 consecutive spawns (counted from reset or from a bag clear) yields every type exactly once.
- TETRIMINO_BAG_EN undefined: the bag is removed and any non-zero candidate is accepted. After 8 zero candidates, type 1 is forced. Maximum DRAW length is still 8 cycles.

## Test plan
- Reset check: hold rst for 3 cycles, then idle for 20 cycles -> matrixOut all 0, typeOut 0, rotOut 0, valid 0, spawnAck 0 throughout.
- Forced L at defaults: spawnReq with spawnType=1 -> after 2 edges, rows 0..2 = 8'h10, 8'h10, 8'h18; rows 3..7 = 0; typeOut 1, rotOut 0, spawnAck one-cycle pulse.
- Forced I rotation: spawnType=6, then one rotReq -> row 2 = 8'h3C, all other rows 0, rotOut 1. Three more rotReq -> rotOut 0, rows 0..3 = 8'h08.
- Bag sequence (macro on): 7 spawns with spawnType=0 -> typeOut values form a permutation of 1..7, each latency <= 9 cycles. The 8th spawn starts a fresh bag.
- Priority and reset: spawnReq and rotReq together in HOLD -> new piece with rotOut 0. rst pulsed mid-DRAW -> outputs 0 after the rst edge, and the next 7 spawns again form a permutation.
- Macro off: 100 random spawns -> typeOut never 0, each latency <= 9 cycles, valid high after every spawn.
